// File: rtl/idct_coef_feeder_if.sv
// idct_coef_feeder_if: coefficient input stream and IDCT row output bundle
interface idct_coef_feeder_if #(
   parameter int IN_WIDTH = 12,
   parameter int Q_WIDTH = 8,
   parameter int COEF_WIDTH = 32
);
   logic coef_valid;
   logic coef_ready;
   logic [5:0] coef_pos;
   logic signed [IN_WIDTH-1:0] coef_val;
   logic [Q_WIDTH-1:0] coef_q;
   logic coef_last;
   logic idct_busy;
   logic idct_en;
   logic signed [COEF_WIDTH-1:0] row [0:7];
   modport master (
      output coef_valid, coef_pos, coef_val, coef_q, coef_last, idct_busy,
      input coef_ready, idct_en, row
   );
   modport slave (
      input coef_valid, coef_pos, coef_val, coef_q, coef_last, idct_busy,
      output coef_ready, idct_en, row
   );
endinterface

// File: rtl/idct_coef_feeder.sv
// idct_coef_feeder: dequantise zigzag coefficients into an 8x8 buffer and stream its rows to the IDCT
module idct_coef_feeder #(
   parameter int IN_WIDTH = 12,
   parameter int Q_WIDTH = 8,
   parameter int COEF_WIDTH = 32
) (
   input logic aclk,
   input logic areset,
   idct_coef_feeder_if.slave bus
);
   typedef enum logic [1:0] {FILL, WAIT, PRE, SEND} state_t;
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d, ld;
   logic acc;
   logic signed [IN_WIDTH-1:0] val;
   logic [Q_WIDTH-1:0] q;
   logic signed [COEF_WIDTH-1:0] prod;
   logic signed [COEF_WIDTH-1:0] mem_q [64];
   logic signed [COEF_WIDTH-1:0] row_q [0:7];
   assign val = bus.coef_val;
   assign q = bus.coef_q;
   assign prod = COEF_WIDTH'(val) * COEF_WIDTH'(q);
   assign acc = bus.coef_valid && state_q == FILL;
   assign ld = state_q == PRE ? 3'd0 : cnt_q + 3'd1;
   assign bus.coef_ready = state_q == FILL;
   assign bus.idct_en = state_q == PRE || state_q == SEND;
   assign bus.row = row_q;
   // next state: collect until last, wait for the IDCT, one lead-in cycle, then eight rows
   always_comb begin
      state_d = state_q;
      cnt_d = state_q == SEND ? cnt_q + 3'd1 : 3'd0;
      if (state_q == FILL && acc && bus.coef_last) state_d = WAIT;
      if (state_q == WAIT && !bus.idct_busy) state_d = PRE;
      if (state_q == PRE) state_d = SEND;
      if (state_q == SEND && cnt_q == 3'd7) state_d = FILL;
   end
   // control registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= FILL;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end
   // buffer scatter, row staging one cycle ahead of its SEND slot, and clear-behind of sent rows
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < 64; i++) mem_q[i] <= '0;
         for (int i = 0; i < 8; i++) row_q[i] <= '0;
      end else begin
         if (acc) mem_q[ZZ[bus.coef_pos]] <= prod;
         for (int i = 0; i < 8; i++) begin
            if (state_q == WAIT && !bus.idct_busy) row_q[i] <= '0;
            if (state_q == PRE || (state_q == SEND && cnt_q != 3'd7)) row_q[i] <= mem_q[{ld, 3'(i)}];
            if (state_q == SEND) mem_q[{cnt_q, 3'(i)}] <= '0;
         end
      end
   end
endmodule

// File: tb/tb_idct_coef_feeder.sv
// tb_idct_coef_feeder: table-driven and scoreboard checks of the coefficient feeder
module tb_idct_coef_feeder;
   typedef struct {
      int pos;
      int val;
      int q;
      int r;
      int c;
      longint v;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int tests = 0;
   int fails = 0;
   int zz [64];
   longint model [64];
   longint sb [$];
   longint cur [64];
   int run = 0;
   vec_t tbl [9];
   int w;
   idct_coef_feeder_if #(.IN_WIDTH(12), .Q_WIDTH(8), .COEF_WIDTH(32)) bus ();
   idct_coef_feeder #(.IN_WIDTH(12), .Q_WIDTH(8), .COEF_WIDTH(32)) dut (
      .aclk(clk),
      .areset(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input longint a, input longint e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", n, a, e);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push_model();
      for (int k = 0; k < 64; k++) begin
         sb.push_back(model[k]);
         model[k] = 0;
      end
   endtask
   task automatic send(input int pos, input int val, input int q, input bit last, output int waited);
      bit r;
      r = 1'b0;
      waited = -1;
      bus.coef_valid = 1'b1;
      bus.coef_pos = 6'(pos);
      bus.coef_val = 12'(val);
      bus.coef_q = 8'(q);
      bus.coef_last = last;
      for (int i = 0; i < 40 && waited < 0; i++) begin
         r = bus.coef_ready;
         step();
         if (r) waited = i;
      end
      bus.coef_valid = 1'b0;
      bus.coef_last = 1'b0;
      chk("accepted", longint'(r), 1);
   endtask
   task automatic put(input int pos, input int val, input int q, input bit last, output int waited);
      model[zz[pos]] = longint'(val) * longint'(q);
      send(pos, val, q, last, waited);
      if (last) push_model();
   endtask
   task automatic run_block(input int stall);
      for (int i = 0; i < stall; i++) begin
         chk("stall_en", longint'(bus.idct_en), 0);
         chk("stall_ready", longint'(bus.coef_ready), 0);
         step();
      end
      bus.idct_busy = 1'b0;
      chk("wait_en", longint'(bus.idct_en), 0);
      chk("wait_ready", longint'(bus.coef_ready), 0);
      step();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("en_cycle%0d", i), longint'(bus.idct_en), 1);
         chk($sformatf("busy_ready%0d", i), longint'(bus.coef_ready), 0);
         step();
      end
      chk("done_en", longint'(bus.idct_en), 0);
      chk("done_ready", longint'(bus.coef_ready), 1);
   endtask
   // row monitor: pops one expected block per enable burst and checks lead-in, rows and burst length
   always @(negedge clk) begin
      if (rst) run = 0;
      else if (bus.idct_en === 1'b1) begin
         if (run == 0) begin
            if (sb.size() < 64) begin
               chk("block_expected", sb.size(), 64);
               for (int k = 0; k < 64; k++) cur[k] = 0;
            end else for (int k = 0; k < 64; k++) cur[k] = sb.pop_front();
            for (int c = 0; c < 8; c++) chk($sformatf("pre_row[%0d]", c), bus.row[c], 0);
         end else if (run <= 8)
            for (int c = 0; c < 8; c++) chk($sformatf("row%0d[%0d]", run - 1, c), bus.row[c], cur[(run - 1) * 8 + c]);
         run++;
      end else if (run != 0) begin
         chk("en_len", run, 9);
         run = 0;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "timeout");
   end
   initial begin
      int r, c;
      tbl = '{
         '{0, 5, 16, 0, 0, 80},
         '{9, -2048, 255, 3, 0, -522240},
         '{0, 1, 1, 0, 0, 1},
         '{63, 1, 1, 7, 7, 1},
         '{62, -1, 200, 7, 6, -200},
         '{5, 2047, 255, 0, 2, 521985},
         '{8, -3, 3, 2, 1, -9},
         '{1, 100, 128, 0, 1, 12800},
         '{4, 0, 9, 1, 1, 0}
      };
      r = 0;
      c = 0;
      for (int k = 0; k < 64; k++) begin
         zz[k] = r * 8 + c;
         if ((r + c) % 2 == 0) begin
            if (c == 7) r++;
            else if (r == 0) c++;
            else begin r--; c++; end
         end else begin
            if (r == 7) c++;
            else if (c == 0) r++;
            else begin r++; c--; end
         end
      end
      for (int k = 0; k < 64; k++) model[k] = 0;
      rst = 1'b1;
      bus.coef_valid = 1'b0;
      bus.coef_pos = '0;
      bus.coef_val = '0;
      bus.coef_q = '0;
      bus.coef_last = 1'b0;
      bus.idct_busy = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      chk("reset_en", longint'(bus.idct_en), 0);
      chk("reset_ready", longint'(bus.coef_ready), 1);
      for (int k = 0; k < 8; k++) chk($sformatf("reset_row[%0d]", k), bus.row[k], 0);
      foreach (tbl[i]) begin
         model[tbl[i].r * 8 + tbl[i].c] = tbl[i].v;
         send(tbl[i].pos, tbl[i].val, tbl[i].q, 1'b1, w);
         push_model();
         run_block(0);
      end
      for (int p = 0; p < 64; p++) put(p, p, 1, p == 63, w);
      run_block(0);
      chk("zz_row0_col4", cur[4], 14);
      put(20, 6, 3, 1'b0, w);
      bus.idct_busy = 1'b1;
      put(10, 3, 2, 1'b1, w);
      run_block(5);
      put(20, 11, 2, 1'b0, w);
      put(7, -5, 4, 1'b1, w);
      put(63, 9, 1, 1'b0, w);
      chk("bp_accept_cycle", w, 10);
      put(4, 3, 1, 1'b0, w);
      put(4, 7, 1, 1'b1, w);
      run_block(0);
      chk("dup_row1_col1", cur[9], 7);
      put(0, 1, 1, 1'b0, w);
      put(62, 4, 1, 1'b1, w);
      repeat (6) step();
      chk("row4_en", longint'(bus.idct_en), 1);
      rst = 1'b1;
      step();
      chk("midrst_en", longint'(bus.idct_en), 0);
      chk("midrst_ready", longint'(bus.coef_ready), 1);
      for (int k = 0; k < 8; k++) chk($sformatf("midrst_row[%0d]", k), bus.row[k], 0);
      rst = 1'b0;
      put(63, 1, 1, 1'b1, w);
      run_block(0);
      repeat (3) step();
      chk("sb_empty", sb.size(), 0);
      chk("idle_en", longint'(bus.idct_en), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
